// File: rtl/req_enc_pkg.sv
// Shared constants and state type for the 16-to-4 request vector encoder.
package req_enc_pkg;

  localparam int WIDTH = 16;
  localparam int IDXW  = $clog2(WIDTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/req_vector_encoder_lsb.sv
// Combinational lowest-set-bit encoder with a single-bit-set flag.
module lsb_encoder
  import req_enc_pkg::*;
#(
  parameter int P_WIDTH = WIDTH,
  localparam int P_IDXW = $clog2(P_WIDTH)
) (
  input  logic [P_WIDTH-1:0] i_vec,
  output logic [P_IDXW-1:0]  o_idx,
  output logic               o_onehot
);

  logic [P_WIDTH-1:0] w_minus1;

  assign w_minus1 = i_vec - P_WIDTH'(1);
  assign o_onehot = (i_vec != '0) && ((i_vec & w_minus1) == '0);

  // Scanning from the top down lets the lowest set bit win.
  always_comb begin
    o_idx = '0;
    for (int k = P_WIDTH - 1; k >= 0; k--) begin
      if (i_vec[k]) o_idx = P_IDXW'(k);
    end
  end

endmodule

// File: rtl/req_vector_encoder.sv
// Accepts a request vector and streams the index of each set bit, lowest first.
//   state    | meaning
//   ST_IDLE  | waiting for a vector; in_ready high
//   ST_DRAIN | emitting indices of pending bits; out_valid high
module req_vector_encoder
  import req_enc_pkg::*;
#(
  parameter int P_WIDTH = WIDTH,
  localparam int P_IDXW = $clog2(P_WIDTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [P_WIDTH-1:0] i_in_vec,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [P_IDXW-1:0]  o_out_idx,
  output logic               o_out_last,
  output logic               o_busy,
  output logic               o_zero_drop
);

  state_e             r_state;
  logic [P_WIDTH-1:0] r_pending;
  logic               r_zero_drop;

  logic [P_IDXW-1:0]  w_idx;
  logic               w_onehot;
  logic               w_drain;
  logic [P_WIDTH-1:0] w_pending_next;

  lsb_encoder #(.P_WIDTH(P_WIDTH)) u_lsb (
    .i_vec    (r_pending),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  assign w_drain        = (r_state == ST_DRAIN);
  // Clearing the lowest set bit is exactly clearing bit w_idx.
  assign w_pending_next = r_pending & (r_pending - P_WIDTH'(1));

  assign o_in_ready  = ~w_drain;
  assign o_out_valid = w_drain;
  assign o_busy      = w_drain;
  assign o_out_idx   = w_drain ? w_idx : '0;
  assign o_out_last  = w_drain & w_onehot;
  assign o_zero_drop = r_zero_drop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_pending   <= '0;
      r_zero_drop <= 1'b0;
    end else begin
      r_zero_drop <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            if (i_in_vec != '0) begin
              r_pending <= i_in_vec;
              r_state   <= ST_DRAIN;
            end else begin
              r_zero_drop <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (i_out_ready) begin
            r_pending <= w_pending_next;
            if (w_onehot) r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_pending <= '0;
        end
      endcase
    end
  end

endmodule
